out_port_alloc_rr: RTL and testbench

//  Per-output-port switch allocator for the 5-port wormhole router, one instance per output port.

---
 rtl/out_port_alloc_rr.sv | 139 +++++++++++++
 tb/tb_out_port_alloc_rr.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/out_port_alloc_rr.sv
// ============================================================================
// out_port_alloc_rr : per-output switch allocator, multicast-first round robin
//                     with starvation guard and per-packet grant lock.
// Revision 1.0
// ============================================================================
`default_nettype none

module out_port_alloc_rr #(
  parameter int NPORT        = 5,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] u_req_i,
  input  logic [NPORT-1:0] m_req_i,
  input  logic [NPORT-1:0] multab_ct_i,
  input  logic [NPORT-1:0] flit_tail_i,
  input  logic             out_ready_i,
  output logic [NPORT-1:0] grt_o,
  output logic             grt_mcast_o,
  output logic             busy_o
);

  localparam int               PTR_W      = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [NPORT-1:0] C_ONE      = {{(NPORT-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_STARVE   = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(NPORT - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q;
  logic [NPORT-1:0]   grt_q;
  logic               grt_mcast_q;
  logic               busy_q;
  logic [PTR_W-1:0]   m_ptr_q;
  logic [PTR_W-1:0]   u_ptr_q;
  logic [CNT_W-1:0]   starve_cnt_q;
  logic [CNT_W-1:0]   starve_cnt_d;

  logic [NPORT-1:0]   m_el;
  logic [NPORT-1:0]   u_el;
  logic               sel_m;
  logic [NPORT-1:0]   cls_vec;
  logic [PTR_W-1:0]   win_idx;
  logic               have_win;
  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               xfer;
  logic               tail;

  function automatic logic [PTR_W-1:0] rr_pick(input logic [NPORT-1:0] vec,
                                               input logic [PTR_W-1:0] ptr);
    int   idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(ptr) + k) % NPORT;
      if (!found && vec[idx]) begin
        found   = 1'b1;
        rr_pick = PTR_W'(idx);
      end
    end
  endfunction

  // A port offering both classes competes only as multicast.
  assign m_el     = m_req_i & ~multab_ct_i;
  assign u_el     = u_req_i & ~m_el;
  assign sel_m    = (|m_el) && !((starve_cnt_q == C_STARVE) && (|u_el));
  assign cls_vec  = sel_m ? m_el : u_el;
  assign have_win = |cls_vec;
  assign win_idx  = rr_pick(cls_vec, sel_m ? m_ptr_q : u_ptr_q);

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grt_q[i]) owner_idx = PTR_W'(i);
    end
  end

  assign nxt_ptr = (owner_idx == C_LAST_IDX) ? '0 : owner_idx + 1'b1;
  assign xfer    = out_ready_i & (|(grt_q & (u_req_i | m_req_i)));
  assign tail    = |(grt_q & flit_tail_i);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!sel_m) begin
      starve_cnt_d = '0;
    end else if (|u_el) begin
      starve_cnt_d = (starve_cnt_q == C_STARVE) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grt_q        <= '0;
      grt_mcast_q  <= 1'b0;
      busy_q       <= 1'b0;
      m_ptr_q      <= '0;
      u_ptr_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (have_win && out_ready_i) begin
            grt_q        <= C_ONE << win_idx;
            grt_mcast_q  <= sel_m;
            busy_q       <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            state_q      <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && tail) begin
            grt_q       <= '0;
            grt_mcast_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            if (grt_mcast_q) m_ptr_q <= nxt_ptr;
            else             u_ptr_q <= nxt_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grt_o       = grt_q;
  assign grt_mcast_o = grt_mcast_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_out_port_alloc_rr.sv
// ============================================================================
// tb_out_port_alloc_rr : directed self-checking bench for out_port_alloc_rr.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_out_port_alloc_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] u_req, m_req, multab, tails;
  logic       ready;
  logic [4:0] grt;
  logic       mcast, busy;
  logic [6:0] obs;
  int         n_vec  = 0;
  int         n_miss = 0;

  assign obs = {busy, mcast, grt};

  always #5 clk = ~clk;

  out_port_alloc_rr #(.NPORT(5), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .u_req_i     (u_req),
    .m_req_i     (m_req),
    .multab_ct_i (multab),
    .flit_tail_i (tails),
    .out_ready_i (ready),
    .grt_o       (grt),
    .grt_mcast_o (mcast),
    .busy_o      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    u_req = '0; m_req = '0; multab = '0; tails = '0; ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // obs = {busy, mcast, grt}
  task automatic test_reset();
    do_reset();
    n_vec++;
    if (obs !== 7'b0_0_00000) begin
      n_miss++; $display("FAIL reset_state: got %b want %b", obs, 7'b0_0_00000);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    u_req = 5'b10100; tails = 5'b11111; ready = 1'b1;
    step();
    n_vec++;
    if (obs !== 7'b1_0_00100) begin
      n_miss++; $display("FAIL rr_first: got %b want %b", obs, 7'b1_0_00100);
    end
    step();
    n_vec++;
    if (obs !== 7'b0_0_00000) begin
      n_miss++; $display("FAIL rr_release: got %b want %b", obs, 7'b0_0_00000);
    end
    step();
    n_vec++;
    if (obs !== 7'b1_0_10000) begin
      n_miss++; $display("FAIL rr_second: got %b want %b", obs, 7'b1_0_10000);
    end
    step();
    u_req = 5'b10001;
    step();
    n_vec++;
    if (obs !== 7'b1_0_00001) begin
      n_miss++; $display("FAIL rr_wrap: got %b want %b", obs, 7'b1_0_00001);
    end
    step();
  endtask

  task automatic test_mcast_prio();
    do_reset();
    m_req = 5'b00010; u_req = 5'b00001; tails = 5'b11111; ready = 1'b1;
    step();
    n_vec++;
    if (obs !== 7'b1_1_00010) begin
      n_miss++; $display("FAIL mcast_prio: got %b want %b", obs, 7'b1_1_00010);
    end
    step();
    multab = 5'b00010;
    step();
    n_vec++;
    if (obs !== 7'b1_0_00001) begin
      n_miss++; $display("FAIL multab_mask: got %b want %b", obs, 7'b1_0_00001);
    end
    step();
  endtask

  task automatic test_multiflit();
    logic [5:0] rdy_seq;
    int         xfers;
    logic [6:0] exp;
    rdy_seq = 6'b101101;   // applied LSB first: 1,0,1,1,0,1
    xfers = 0;
    do_reset();
    u_req = 5'b01000; ready = 1'b1;
    step();
    u_req = 5'b01001;
    for (int i = 0; i < 6; i++) begin
      ready = rdy_seq[i];
      tails = (xfers == 3) ? 5'b01000 : 5'b00000;
      step();
      if (rdy_seq[i]) xfers++;
      exp = (i == 5) ? 7'b0_0_00000 : 7'b1_0_01000;
      n_vec++;
      if (obs !== exp) begin
        n_miss++; $display("FAIL multiflit_c%0d: got %b want %b", i, obs, exp);
      end
    end
    tails = 5'b11111; ready = 1'b1;
    step();
    n_vec++;
    if (obs !== 7'b1_0_00001) begin
      n_miss++; $display("FAIL multiflit_next: got %b want %b", obs, 7'b1_0_00001);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [6:0] exp;
    do_reset();
    m_req = 5'b00100; u_req = 5'b00001; tails = 5'b11111; ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      step();
      exp = (p == 8) ? 7'b1_0_00001 : 7'b1_1_00100;
      n_vec++;
      if (obs !== exp) begin
        n_miss++; $display("FAIL starve_pkt%0d: got %b want %b", p, obs, exp);
      end
      step();
      n_vec++;
      if (obs !== 7'b0_0_00000) begin
        n_miss++; $display("FAIL starve_rel%0d: got %b want %b", p, obs, 7'b0_0_00000);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    u_req = 5'b01000; tails = 5'b11111; ready = 1'b1;
    step();
    step();
    u_req = 5'b00010; tails = 5'b00000;
    step();
    step();
    n_vec++;
    if (obs !== 7'b1_0_00010) begin
      n_miss++; $display("FAIL arst_locked: got %b want %b", obs, 7'b1_0_00010);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 7'b0_0_00000) begin
      n_miss++; $display("FAIL arst_immediate: got %b want %b", obs, 7'b0_0_00000);
    end
    step();
    rst = 1'b0;
    u_req = 5'b10110; tails = 5'b11111;
    step();
    n_vec++;
    if (obs !== 7'b1_0_00010) begin
      n_miss++; $display("FAIL arst_lowest: got %b want %b", obs, 7'b1_0_00010);
    end
    step();
  endtask

  task automatic test_no_ready();
    do_reset();
    u_req = 5'b00100; tails = 5'b11111; ready = 1'b1;
    step();
    step();
    u_req = 5'b10011; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs !== 7'b0_0_00000) begin
        n_miss++; $display("FAIL noready_c%0d: got %b want %b", i, obs, 7'b0_0_00000);
      end
    end
    u_req = 5'b10001; ready = 1'b1;
    step();
    n_vec++;
    if (obs !== 7'b1_0_10000) begin
      n_miss++; $display("FAIL noready_ptr: got %b want %b", obs, 7'b1_0_10000);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_rr_wrap();
    test_mcast_prio();
    test_multiflit();
    test_starvation();
    test_async_reset();
    test_no_ready();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
